data_ram_arbiter: RTL

Two-master arbiter and burst sequencer in front of the word-organised data RAM (4 byte lanes, combinational read, write on rising edge). Master 0 is the CPU MEM stage: single-word accesses, served in the same cycle and stalled when blocked. Master 1 is a DMA/debug loader: word bursts of 1..2^LEN_W beats with auto-incrementing address. CPU has priority, but a wait counter bounds DMA starvation. The block sits between the MEM stage / loader and the RAM's ce/we/addr/sel/data pins.

---
 rtl/data_ram_arbiter_if.sv | 49 ++++
 rtl/data_ram_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA/debug loader, the arbiter and the data RAM.
// The master modport is the environment side (both requesters plus the RAM's read port).
interface data_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 4
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [3:0]        m0_sel;
  logic [31:0]       m0_wdata;
  logic [31:0]       m0_rdata;
  logic              m0_stall;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [3:0]        m1_sel;
  logic [LEN_W-1:0]  m1_len;
  logic [31:0]       m1_wdata;
  logic [31:0]       m1_rdata;
  logic              m1_ack;
  logic              m1_done;

  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_rdata, m0_stall,
    output m1_req, m1_we, m1_addr, m1_sel, m1_len, m1_wdata,
    input  m1_rdata, m1_ack, m1_done,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_rdata, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_len, m1_wdata,
    output m1_rdata, m1_ack, m1_done,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-master data RAM arbiter: CPU single-word accesses with priority, DMA word bursts
// with auto-incrementing address and a bounded starvation wait.
module data_ram_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LEN_W    = 4
) (
  input logic               clk,
  input logic               rst_n,
  data_ram_arbiter_if.slave bus
);
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        r_state;
  logic [CntW-1:0]   r_wait_cnt;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [ADDR_W-1:0] r_b_addr;
  logic              r_b_we;
  logic [3:0]        r_b_sel;

  logic w_idle;
  logic w_burst;
  logic w_start;
  logic w_last;
  logic w_unused_addr;

  // Gating with rst_n keeps every output at 0 while reset is held, even mid-burst.
  assign w_idle  = rst_n && (r_state == ST_IDLE);
  assign w_burst = rst_n && (r_state == ST_BURST);
  assign w_start = w_idle && bus.m1_req &&
                   (!bus.m0_req || (r_wait_cnt == CntW'(MAX_WAIT)));
  assign w_last  = w_burst && (r_beat_cnt == '0);

  assign w_unused_addr = ^bus.m1_addr[1:0];

  always_comb begin
    bus.ram_ce    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_sel   = '0;
    bus.ram_wdata = '0;
    bus.m0_rdata  = '0;
    bus.m0_stall  = 1'b0;
    bus.m1_rdata  = '0;
    bus.m1_ack    = 1'b0;
    bus.m1_done   = 1'b0;
    if (w_idle && bus.m0_req) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = bus.m0_we;
      bus.ram_addr  = bus.m0_addr;
      bus.ram_sel   = bus.m0_sel;
      bus.ram_wdata = bus.m0_wdata;
      bus.m0_rdata  = bus.m0_we ? 32'h0 : bus.ram_rdata;
    end else if (w_burst) begin
      bus.ram_ce    = 1'b1;
      bus.ram_we    = r_b_we;
      bus.ram_addr  = r_b_addr;
      bus.ram_sel   = r_b_sel;
      bus.ram_wdata = bus.m1_wdata;
      bus.m0_stall  = bus.m0_req;
      bus.m1_ack    = 1'b1;
      bus.m1_done   = w_last;
      bus.m1_rdata  = r_b_we ? 32'h0 : bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_beat_cnt <= '0;
      r_b_addr   <= '0;
      r_b_we     <= 1'b0;
      r_b_sel    <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_start) begin
        r_state    <= ST_BURST;
        r_wait_cnt <= '0;
        r_beat_cnt <= bus.m1_len;
        r_b_addr   <= {bus.m1_addr[ADDR_W-1:2], 2'b00};
        r_b_we     <= bus.m1_we;
        r_b_sel    <= bus.m1_sel;
      end else if (bus.m1_req && bus.m0_req) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end else begin
      r_b_addr <= r_b_addr + ADDR_W'(4);
      if (r_beat_cnt == '0) begin
        r_state <= ST_IDLE;
      end else begin
        r_beat_cnt <= r_beat_cnt - 1'b1;
      end
    end
  end
endmodule
